// File: rtl/aoc_pkg.sv
// Shared types and helpers for the stack drain reader.
// Data width falls back to 8 bits when no common header defines it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package aoc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      POP,
      WAIT,
      DONE
   } drain_state_t;

   localparam int DIGIT_MAX = 9;
   localparam int MUL_W     = 64;

   // x*10 as two shifts and an add; wraps at MUL_W bits
   function automatic logic [MUL_W-1:0] mul10(input logic [MUL_W-1:0] v);
      return (v << 3) + (v << 1);
   endfunction

endpackage

// File: rtl/digit_mac.sv
// Decimal digit accumulator: acc += digit*weight, weight *= 10 per entry.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module digit_mac
   import aoc_pkg::*;
#(
   parameter int RESULT_WIDTH = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    en,
   input  logic [`DATA_WIDTH-1:0]  digit,
   output logic [RESULT_WIDTH-1:0] acc
);

   logic [RESULT_WIDTH-1:0] weight;
   logic [RESULT_WIDTH-1:0] digit_ext;
   logic [MUL_W-1:0]        weight_x10;

   assign digit_ext  = RESULT_WIDTH'(digit);
   assign weight_x10 = mul10(MUL_W'(weight));

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         acc    <= '0;
         weight <= RESULT_WIDTH'(1);
      end else if (en) begin
         acc    <= acc + digit_ext * weight;
         weight <= RESULT_WIDTH'(weight_x10);
      end
   end

endmodule

// File: rtl/stack_drain.sv
// Pops a loaded stack top-first and rebuilds the decimal number it spells,
// presenting it on a valid/ready port and keeping a running total.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module stack_drain
   import aoc_pkg::*;
#(
   parameter int MAX_CAP      = 4,
   parameter int RESULT_WIDTH = 64
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [$clog2(MAX_CAP):0]  stack_size,
   input  logic                      stack_empty,
   output logic                      pop,
   input  logic [`DATA_WIDTH-1:0]    pop_data,
   input  logic                      pop_data_valid,
   output logic [RESULT_WIDTH-1:0]   result,
   output logic                      result_valid,
   input  logic                      result_ready,
   input  logic                      clear_total,
   output logic [RESULT_WIDTH-1:0]   total,
   output logic                      busy,
   output logic                      digit_err
);

   localparam int CW = $clog2(MAX_CAP) + 1;
   localparam logic [`DATA_WIDTH-1:0] DMAX = `DATA_WIDTH'(DIGIT_MAX);

   drain_state_t            state;
   logic [CW-1:0]           remaining;
   logic                    accept;
   logic                    take;
   logic                    last;
   logic [RESULT_WIDTH-1:0] acc;

   assign accept = (state == IDLE) && start;
   assign take   = (state == WAIT) && pop_data_valid;
   assign last   = remaining <= CW'(1);

   // acc is only written in WAIT, so it doubles as the held result
   digit_mac #(
      .RESULT_WIDTH(RESULT_WIDTH)
   ) u_mac (
      .clock (clock),
      .reset (reset),
      .clear (accept),
      .en    (take),
      .digit (pop_data),
      .acc   (acc)
   );

   assign pop          = (state == POP);
   assign busy         = (state != IDLE);
   assign result_valid = (state == DONE);
   assign result       = acc;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         total     <= '0;
         digit_err <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (clear_total)
                  total <= '0;
               if (start) begin
                  if (stack_empty) begin
                     state <= DONE;
                  end else begin
                     remaining <= stack_size;
                     state     <= POP;
                  end
               end
            end
            POP: state <= WAIT;
            WAIT: begin
               if (pop_data_valid) begin
                  remaining <= remaining - CW'(1);
                  state     <= last ? DONE : POP;
                  if (pop_data > DMAX)
                     digit_err <= 1'b1;
               end
            end
            DONE: begin
               if (result_ready) begin
                  total <= total + result;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_drain.sv
// Bench for stack_drain: a stack model answers pops, banks are checked
// against a bottom-to-top decimal reference and a running total.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_stack_drain;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  stack_size;
   logic        stack_empty;
   logic        pop;
   logic [7:0]  pop_data;
   logic        pop_data_valid;
   logic [63:0] result;
   logic        result_valid;
   logic        result_ready;
   logic        clear_total;
   logic [63:0] total;
   logic        busy;
   logic        digit_err;

   stack_drain #(.MAX_CAP(4), .RESULT_WIDTH(64)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .stack_size     (stack_size),
      .stack_empty    (stack_empty),
      .pop            (pop),
      .pop_data       (pop_data),
      .pop_data_valid (pop_data_valid),
      .result         (result),
      .result_valid   (result_valid),
      .result_ready   (result_ready),
      .clear_total    (clear_total),
      .total          (total),
      .busy           (busy),
      .digit_err      (digit_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      int               n;
      logic [3:0][7:0]  d;
      longint unsigned  exp;
      int               hold;
   } vec_t;

   int              n_cmp = 0;
   int              n_bad = 0;
   int              pops = 0;
   logic [7:0]      mem [4];
   int              depth = 0;
   logic            pend = 1'b0;
   logic [7:0]      pend_val = '0;
   longint unsigned exp_total = 0;
   logic            exp_err = 1'b0;
   vec_t            vt [5];

   task automatic chk(input string name, input longint unsigned act,
                      input longint unsigned req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   function automatic logic [3:0][7:0] mk(input int a, input int b,
                                          input int c, input int e);
      return {8'(e), 8'(c), 8'(b), 8'(a)};
   endfunction

   // decimal value the entries spell, bottom (index 0) most significant
   function automatic longint unsigned spell(input int n,
                                             input logic [3:0][7:0] d);
      longint unsigned r = 0;
      for (int i = 0; i < n; i++) r = r * 10 + longint'(d[i]);
      return r;
   endfunction

   // one cycle; long_stack model answers a pop one cycle later
   task automatic step();
      @(negedge clock);
      pop_data_valid = 1'b0;
      if (pend) begin
         pop_data       = pend_val;
         pop_data_valid = 1'b1;
         pend           = 1'b0;
      end
      if (pop) begin
         pops++;
         if (depth > 0) begin
            depth--;
            pend_val = mem[depth];
            pend     = 1'b1;
         end
      end
      stack_size  = 3'(depth);
      stack_empty = (depth == 0);
   endtask

   task automatic load(input int n, input logic [3:0][7:0] d);
      for (int i = 0; i < n; i++) mem[i] = d[i];
      depth       = n;
      stack_size  = 3'(n);
      stack_empty = (n == 0);
   endtask

   task automatic run_bank(input string tag, input int n,
                           input logic [3:0][7:0] d, input int hold);
      int              k;
      int              np0;
      logic            stable;
      logic [63:0]     r0;
      longint unsigned want;
      want = spell(n, d);
      for (int i = 0; i < n; i++) if (d[i] > 9) exp_err = 1'b1;
      load(n, d);
      np0   = pops;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (!result_valid && k < 60) begin
         step();
         k++;
      end
      if (!result_valid) begin
         chk({tag, " timeout"}, 0, 1);
         return;
      end
      chk({tag, " latency"}, k + 1, (n == 0) ? 1 : 2 * n + 1);
      chk({tag, " result"}, result, want);
      r0     = result;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         step();
         if (result !== r0 || !result_valid) stable = 1'b0;
      end
      if (hold > 0) chk({tag, " stable"}, stable, 1);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      exp_total += want;
      chk({tag, " pops"}, pops - np0, n);
      chk({tag, " rv_fall"}, result_valid, 0);
      chk({tag, " total"}, total, exp_total);
      chk({tag, " digit_err"}, digit_err, exp_err);
   endtask

   initial begin
      int np0;
      int k;
      int n;
      logic [3:0][7:0] d;

      reset          = 1'b1;
      start          = 1'b0;
      stack_size     = '0;
      stack_empty    = 1'b1;
      pop_data       = '0;
      pop_data_valid = 1'b0;
      result_ready   = 1'b0;
      clear_total    = 1'b0;
      step();
      step();
      chk("rst pop", pop, 0);
      chk("rst rv", result_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst total", total, 0);
      chk("rst err", digit_err, 0);
      chk("rst result", result, 0);
      reset = 1'b0;
      step();

      vt[0] = '{2, mk(9, 8, 0, 0), 98, 0};
      vt[1] = '{4, mk(7, 2, 4, 6), 7246, 3};
      vt[2] = '{1, mk(5, 0, 0, 0), 5, 1};
      vt[3] = '{3, mk(1, 0, 0, 0), 100, 0};
      vt[4] = '{0, mk(0, 0, 0, 0), 0, 2};
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("tbl%0d model", i), spell(vt[i].n, vt[i].d),
             vt[i].exp);
         run_bank($sformatf("tbl%0d", i), vt[i].n, vt[i].d, vt[i].hold);
      end

      clear_total = 1'b1;
      step();
      clear_total = 1'b0;
      exp_total   = 0;
      chk("clr total", total, 0);
      run_bank("empty", 0, mk(0, 0, 0, 0), 0);
      run_bank("after_empty", 2, mk(2, 1, 0, 0), 0);

      // start while busy must be dropped; clear_total only works in IDLE
      load(2, mk(3, 4, 0, 0));
      np0   = pops;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (!result_valid && k < 60) begin
         step();
         k++;
      end
      chk("bp reached done", result_valid, 1);
      start       = 1'b1;
      clear_total = 1'b1;
      step();
      start       = 1'b0;
      clear_total = 1'b0;
      chk("bp held", result_valid, 1);
      chk("bp total kept", total, exp_total);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      exp_total += 34;
      chk("bp total", total, exp_total);
      step();
      chk("bp no queued start", busy, 0);
      chk("bp pops", pops - np0, 2);
      clear_total = 1'b1;
      step();
      clear_total = 1'b0;
      exp_total   = 0;
      chk("bp clear idle", total, 0);

      run_bank("bad_digit", 2, mk(3, 12, 0, 0), 1);
      run_bank("clean_after_bad", 2, mk(4, 4, 0, 0), 0);

      // reset in the middle of a 4-entry drain
      load(4, mk(1, 2, 3, 4));
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("mid in wait", busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_total = 0;
      exp_err   = 1'b0;
      chk("mid pop", pop, 0);
      chk("mid busy", busy, 0);
      chk("mid rv", result_valid, 0);
      chk("mid total", total, 0);
      chk("mid err", digit_err, 0);
      step();
      step();
      chk("mid pop later", pop, 0);
      run_bank("post_reset", 2, mk(5, 5, 0, 0), 0);

      for (int t = 0; t < 25; t++) begin
         n = int'($urandom_range(0, 4));
         for (int i = 0; i < 4; i++)
            d[i] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(10, 15))
                                               : 8'($urandom_range(0, 9));
         run_bank($sformatf("rnd%0d", t), n, d,
                  int'($urandom_range(0, 2)));
         if ($urandom_range(0, 4) == 0) begin
            clear_total = 1'b1;
            step();
            clear_total = 1'b0;
            exp_total   = 0;
            chk($sformatf("rnd%0d clr", t), total, 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
